dp_rr_arbiter: RTL and testbench

- Shares the single register-file/ALU datapath between two independent requesters (e.g. the sequencing FSM and a debug/test-load port).
- Accepts one operation at a time under valid/ready, arbitrates round-robin, and drives the datapath control bus for exactly one execute cycle.
- Captures result Z and flags, and returns them to the winning requester with a one-cycle response pulse.

---
 rtl/dp_rr_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_dp_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_rr_arbiter.sv
// dp_rr_arbiter
// Shares one register-file/ALU datapath between two requesters. One
// operation is accepted at a time, arbitrated round-robin, executed for a
// single cycle on the datapath control bus, and its result Z/flags are
// returned with a one-cycle response pulse to the requester that won.
//
// Handshake: a request i is consumed on the cycle req_valid[i] & req_ready[i].
// req_ready is a combinational one-hot pulse raised only in IDLE. A requester
// may hold req_valid through EXEC/RESP without being consumed twice.
//
// Timing: accept at cycle N, execute (control bus driven) at N+1,
// rsp_valid at N+2. Throughput is one operation per three cycles.
//
// Optional feature: define DP_ARB_LOCK_EN to add req_lock[1:0]. A requester
// granted with its lock bit set keeps priority over a competitor for as
// long as it re-requests with lock held.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   2-bit request / one-hot accept
//   req{0,1}_*            per-requester operation fields
//   req_lock              (DP_ARB_LOCK_EN only) per-requester lock
//   selectImm..op         datapath control bus
//   Z, flags              datapath result (combinational from the bus)
//   rsp_valid/id/data/flags  response
//   busy                  high in any state other than IDLE
//   dbg_state_o           current FSM state (0 IDLE, 1 EXEC, 2 RESP)

module dp_rr_arbiter #(
  parameter int          DATA_W   = 16,
  parameter int          FLAG_W   = 5,
  parameter logic [3:0]  NOWR_REG = 4'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [7:0]        req0_op,
  input  logic [7:0]        req0_imm,
  input  logic              req0_sel_imm,
  input  logic [3:0]        req0_ra,
  input  logic [3:0]        req0_rb,
  input  logic [3:0]        req0_rd,
  input  logic              req0_wr,
  input  logic [7:0]        req1_op,
  input  logic [7:0]        req1_imm,
  input  logic              req1_sel_imm,
  input  logic [3:0]        req1_ra,
  input  logic [3:0]        req1_rb,
  input  logic [3:0]        req1_rd,
  input  logic              req1_wr,
`ifdef DP_ARB_LOCK_EN
  input  logic [1:0]        req_lock,
`endif
  output logic              selectImm,
  output logic [3:0]        loadReg,
  output logic [3:0]        readRegA,
  output logic [3:0]        readRegB,
  output logic [7:0]        Imm,
  output logic [7:0]        op,
  input  logic [DATA_W-1:0] Z,
  input  logic [FLAG_W-1:0] flags,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   rr_ptr_q;

  // Latched operation of the current winner.
  logic [7:0] op_q, imm_q;
  logic       sel_imm_q, wr_q, id_q;
  logic [3:0] ra_q, rb_q, rd_q;

  // Fields of the requester being granted this cycle.
  logic [7:0] op_d, imm_d;
  logic       sel_imm_d, wr_d;
  logic [3:0] ra_d, rb_d, rd_d;

  logic [DATA_W-1:0] rsp_data_q;
  logic [FLAG_W-1:0] rsp_flags_q;
  logic              rsp_id_q;

  logic gnt_any, gnt_id, prio, exec_act;

`ifdef DP_ARB_LOCK_EN
  logic lock_q;       // lock bit of the in-flight operation
  logic hold_q;       // last completed op was locked
  logic hold_id_q;    // requester that holds the lock
`endif

  // Arbitration and next state.
  always_comb begin
    state_d = state_q;
    gnt_any = 1'b0;
    prio    = rr_ptr_q;
`ifdef DP_ARB_LOCK_EN
    // While a lock is held rr_ptr stays put; the holder wins as long as it
    // keeps its lock up, and priority passes to the other side once it
    // drops the lock.
    if (hold_q) prio = req_lock[hold_id_q] ? hold_id_q : ~hold_id_q;
`endif
    gnt_id = (req_valid == 2'b11) ? prio : req_valid[1];
    case (state_q)
      IDLE: if (req_valid != 2'b00) begin
        gnt_any = 1'b1;
        state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) gnt_any = 1'b0;
    req_ready = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  end

  // Field mux for the requester being granted.
  always_comb begin
    op_d      = gnt_id ? req1_op      : req0_op;
    imm_d     = gnt_id ? req1_imm     : req0_imm;
    sel_imm_d = gnt_id ? req1_sel_imm : req0_sel_imm;
    ra_d      = gnt_id ? req1_ra      : req0_ra;
    rb_d      = gnt_id ? req1_rb      : req0_rb;
    rd_d      = gnt_id ? req1_rd      : req0_rd;
    wr_d      = gnt_id ? req1_wr      : req0_wr;
  end

  // Datapath control bus: driven only in EXEC, idle values otherwise.
  // Gated by reset so the bus is idle for the whole reset cycle.
  always_comb begin
    exec_act  = (state_q == EXEC) && !reset;
    selectImm = 1'b0;
    loadReg   = NOWR_REG;
    readRegA  = 4'd0;
    readRegB  = 4'd0;
    Imm       = 8'd0;
    op        = 8'd0;
    if (exec_act) begin
      selectImm = sel_imm_q;
      loadReg   = wr_q ? rd_q : NOWR_REG;
      readRegA  = ra_q;
      readRegB  = rb_q;
      Imm       = imm_q;
      op        = op_q;
    end
  end

  assign busy        = (state_q != IDLE) && !reset;
  assign rsp_valid   = (state_q == RESP) && !reset;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_flags   = rsp_flags_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      op_q        <= 8'd0;
      imm_q       <= 8'd0;
      sel_imm_q   <= 1'b0;
      ra_q        <= 4'd0;
      rb_q        <= 4'd0;
      rd_q        <= 4'd0;
      wr_q        <= 1'b0;
      id_q        <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_id_q    <= 1'b0;
`ifdef DP_ARB_LOCK_EN
      lock_q      <= 1'b0;
      hold_q      <= 1'b0;
      hold_id_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (gnt_any) begin
        op_q      <= op_d;
        imm_q     <= imm_d;
        sel_imm_q <= sel_imm_d;
        ra_q      <= ra_d;
        rb_q      <= rb_d;
        rd_q      <= rd_d;
        wr_q      <= wr_d;
        id_q      <= gnt_id;
`ifdef DP_ARB_LOCK_EN
        lock_q    <= req_lock[gnt_id];
`endif
      end
      // Z/flags are combinational from the bus, so the closing EXEC edge
      // captures the result of the operation being driven.
      if (state_q == EXEC) begin
        rsp_data_q  <= Z;
        rsp_flags_q <= flags;
        rsp_id_q    <= id_q;
      end
      // Round-robin pointer advances only on completion.
      if (state_q == RESP) begin
`ifdef DP_ARB_LOCK_EN
        if (lock_q) begin
          hold_q    <= 1'b1;
          hold_id_q <= id_q;
        end else begin
          hold_q   <= 1'b0;
          rr_ptr_q <= ~id_q;
        end
`else
        rr_ptr_q <= ~id_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dp_rr_arbiter.sv
// Testbench for dp_rr_arbiter: table of single operations checked against a
// cycle model and a response scoreboard, plus hand sequences for continuous
// contention, reset during EXEC and (with DP_ARB_LOCK_EN) the lock feature.

module tb_dp_rr_arbiter;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] imm;
    logic       sel;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rd;
    logic       wr;
  } req_t;

  typedef struct {
    logic [1:0] vld;
    req_t       a;
    req_t       b;
    int         gnt;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  vld = 2'b00;
  req_t        r0 = '0, r1 = '0;
  logic [1:0]  req_ready;
  logic        selectImm;
  logic [3:0]  loadReg, readRegA, readRegB;
  logic [7:0]  Imm, op;
  logic [15:0] z;
  logic [4:0]  flg;
  logic        rsp_valid, rsp_id, busy;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_flags;
  logic [1:0]  dbg_state;
`ifdef DP_ARB_LOCK_EN
  logic [1:0]  lock = 2'b00;
`endif

  // Datapath stand-in: result is a fixed mix of the control bus.
  assign z   = {op ^ {readRegA, readRegB}, Imm ^ {3'b000, selectImm, loadReg}};
  assign flg = z[15:11] ^ z[4:0];

  dp_rr_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(vld), .req_ready(req_ready),
    .req0_op(r0.op), .req0_imm(r0.imm), .req0_sel_imm(r0.sel),
    .req0_ra(r0.ra), .req0_rb(r0.rb), .req0_rd(r0.rd), .req0_wr(r0.wr),
    .req1_op(r1.op), .req1_imm(r1.imm), .req1_sel_imm(r1.sel),
    .req1_ra(r1.ra), .req1_rb(r1.rb), .req1_rd(r1.rd), .req1_wr(r1.wr),
`ifdef DP_ARB_LOCK_EN
    .req_lock(lock),
`endif
    .selectImm(selectImm), .loadReg(loadReg), .readRegA(readRegA),
    .readRegB(readRegB), .Imm(Imm), .op(op), .Z(z), .flags(flg),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .busy(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- model + scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic        model_on = 1'b1;
  int          m_state = 0;     // 0 IDLE, 1 EXEC, 2 RESP
  logic        m_ptr = 1'b0;
  logic        m_id = 1'b0;
  req_t        m_cur = '0;
  logic [21:0] exp_q[$];        // {id, data, flags}

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dp_z(input req_t r);
    logic [3:0] ld;
    ld = r.wr ? r.rd : 4'd0;
    return {r.op ^ {r.ra, r.rb}, r.imm ^ {3'b000, r.sel, ld}};
  endfunction

  function automatic logic [4:0] dp_f(input logic [15:0] v);
    return v[15:11] ^ v[4:0];
  endfunction

  function automatic req_t mk(input logic [7:0] o, input logic [7:0] im, input logic s,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] d, input logic w);
    req_t r;
    r.op = o; r.imm = im; r.sel = s; r.ra = a; r.rb = b; r.rd = d; r.wr = w;
    return r;
  endfunction

  function automatic req_t rnd();
    return mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)),
              1'($urandom_range(0, 1)));
  endfunction

  // One clock cycle. Entered at posedge+2 with inputs set; checks at the
  // negedge, advances the model at the posedge, returns at posedge+2.
  // g = observed grant id this cycle, or -1.
  task automatic cycle(output int g);
    logic       eg_any;
    logic       eg_id;
    logic [1:0] e_rdy;
    logic [21:0] e;
    @(negedge clk);
    g = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : -1;
    eg_any = !reset && m_state == 0 && vld != 2'b00;
    eg_id  = (vld == 2'b11) ? m_ptr : vld[1];
    e_rdy  = eg_any ? (eg_id ? 2'b10 : 2'b01) : 2'b00;
    if (model_on) begin
      check("ready", req_ready, e_rdy);
      check("busy", busy, !reset && m_state != 0);
      check("rsp_valid", rsp_valid, !reset && m_state == 2);
      check("state", dbg_state, m_state);
      if (!reset && m_state == 1) begin
        check("ex_bus", {op, Imm, selectImm, readRegA, readRegB},
              {m_cur.op, m_cur.imm, m_cur.sel, m_cur.ra, m_cur.rb});
        check("ex_load", loadReg, m_cur.wr ? m_cur.rd : 4'd0);
      end else begin
        check("idle_bus", {op, Imm, selectImm, readRegA, readRegB, loadReg}, 0);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("rsp", {rsp_id, rsp_data, rsp_flags}, e);
        end
      end
    end
    @(posedge clk);
    if (reset) begin
      m_state = 0; m_ptr = 1'b0; exp_q.delete();
    end else begin
      case (m_state)
        0: if (eg_any) begin
          m_cur = eg_id ? r1 : r0;
          m_id = eg_id;
          exp_q.push_back({eg_id, dp_z(m_cur), dp_f(dp_z(m_cur))});
          m_state = 1;
        end
        1: m_state = 2;
        default: begin m_ptr = ~m_id; m_state = 0; end
      endcase
    end
    #2;
  endtask

  task automatic do_reset();
    int g;
    reset = 1'b1;
    vld = 2'b00;
    cycle(g);
    cycle(g);
    reset = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t tbl[8];
  int   g;
  int   gq[$];
  int   cq[$];

  initial begin
    // op, imm, sel, ra, rb, rd, wr
    tbl[0] = '{2'b01, mk(8'h01, 8'h00, 1'b0, 4'd1, 4'd2, 4'd3, 1'b1), rnd(), 0};
    tbl[1] = '{2'b10, rnd(), mk(8'h22, 8'h7F, 1'b1, 4'd4, 4'd5, 4'd6, 1'b0), 1};
    tbl[2] = '{2'b11, rnd(), rnd(), 0};
    tbl[3] = '{2'b11, rnd(), rnd(), 1};
    tbl[4] = '{2'b10, rnd(), rnd(), 1};
    tbl[5] = '{2'b11, rnd(), rnd(), 0};
    tbl[6] = '{2'b01, rnd(), rnd(), 0};
    tbl[7] = '{2'b11, rnd(), rnd(), 1};

    do_reset();
    check("rst_state", dbg_state, 0);
    check("rst_rsp", {rsp_valid, rsp_id, rsp_data, rsp_flags}, 0);

    // Table: one operation per entry, valid held through EXEC and RESP.
    for (int i = 0; i < 8; i++) begin
      vld = tbl[i].vld; r0 = tbl[i].a; r1 = tbl[i].b;
      cycle(g); check("tbl_gnt", g, tbl[i].gnt);
      cycle(g); check("tbl_no_regrant_exec", g, -1);
      cycle(g); check("tbl_no_regrant_resp", g, -1);
    end
    vld = 2'b00;
    cycle(g);
    check("tbl_drained", exp_q.size(), 0);

    // Continuous contention: grants 0,1,0,1 exactly three cycles apart.
    do_reset();
    vld = 2'b11; r0 = rnd(); r1 = rnd();
    for (int c = 0; c < 12; c++) begin
      cycle(g);
      if (g >= 0) begin gq.push_back(g); cq.push_back(c); end
    end
    vld = 2'b00;
    cycle(g);
    check("cont_count", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++) begin
      check("cont_order", gq[k], k % 2);
      check("cont_spacing", cq[k], 3 * k);
    end

    // Reset during EXEC drops the op and clears rr_ptr.
    do_reset();
    vld = 2'b01; r0 = rnd();
    cycle(g); cycle(g); cycle(g);        // completes, rr_ptr -> 1
    vld = 2'b10; r1 = rnd();
    cycle(g); check("rx_gnt1", g, 1);    // accept, next cycle EXEC
    reset = 1'b1; vld = 2'b00;
    cycle(g);                            // reset while in EXEC
    reset = 1'b0;
    check("rx_state_idle", dbg_state, 0);
    check("rx_busy", busy, 0);
    for (int c = 0; c < 3; c++) begin
      cycle(g);
      check("rx_no_rsp", rsp_valid, 0);
    end
    vld = 2'b11; r0 = rnd(); r1 = rnd();
    cycle(g); check("rx_ptr0_gnt", g, 0);
    cycle(g); cycle(g);
    vld = 2'b00;
    cycle(g);

`ifdef DP_ARB_LOCK_EN
    // Locked requester 0 wins three times; after the lock drops, 1 wins.
    do_reset();
    model_on = 1'b0;
    vld = 2'b11; lock = 2'b01;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) lock = 2'b00;
      r0 = rnd(); r1 = rnd();
      cycle(g); check("lock_gnt", g, (k < 3) ? 0 : 1);
      cycle(g); cycle(g);
    end
    vld = 2'b00;
    cycle(g);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
